inst_fetch_unit: RTL

Fetch stage that produces the instruction stream consumed by the decode-stage controller. It generates the PC and drives the 1-cycle-latency inst SRAM port. It presents {instD, pcD, inst_validD, adelD} to decode, with a 1-entry skid register so a stall never loses an in-flight SRAM return. It accepts branch redirects from decode and exception/eret redirects from CP0/exception logic; exception redirects have priority.

---
 rtl/inst_fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC generation, 1-cycle-latency inst SRAM request, and a decode
// output register backed by a 1-entry skid buffer so stalls never drop a return.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallD,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_flush,
  input  logic [ADDR_W-1:0] exc_target,
  output logic              inst_sram_en,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [31:0]       inst_sram_rdata,
  output logic [31:0]       instD,
  output logic [ADDR_W-1:0] pcD,
  output logic              inst_validD,
  output logic              adelD
);

  function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic [ADDR_W-1:0] pc_f_r;
  logic              pend_r;
  logic [ADDR_W-1:0] pend_pc_r;
  logic              pend_adel_r;
  logic              skid_full_r;
  logic [31:0]       skid_inst_r;
  logic [ADDR_W-1:0] skid_pc_r;
  logic              skid_adel_r;

  logic              flush_s;
  logic              issue_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [31:0]       ret_inst_s;

  // Issue decision, next-PC selection and SRAM request
  always_comb begin
    flush_s        = exc_flush | br_redirect;
    issue_s        = !rst && !stallD && !flush_s && !skid_full_r;
    inst_sram_en   = issue_s && !addr_misaligned(pc_f_r);
    inst_sram_addr = pc_f_r;
    ret_inst_s     = pend_adel_r ? 32'd0 : inst_sram_rdata;
    pc_next_s      = pc_f_r;
    if (exc_flush) begin
      pc_next_s = exc_target;
    end else if (br_redirect) begin
      pc_next_s = br_target;
    end else if (issue_s) begin
      pc_next_s = pc_f_r + ADDR_W'(32'd4);
    end else begin
      pc_next_s = pc_f_r;
    end
  end

  // PC, in-flight request tracking, skid buffer and decode output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_r      <= RESET_PC;
      pend_r      <= 1'b0;
      pend_pc_r   <= '0;
      pend_adel_r <= 1'b0;
      skid_full_r <= 1'b0;
      skid_inst_r <= 32'd0;
      skid_pc_r   <= '0;
      skid_adel_r <= 1'b0;
      instD       <= 32'd0;
      pcD         <= '0;
      inst_validD <= 1'b0;
      adelD       <= 1'b0;
    end else begin
      pc_f_r <= pc_next_s;
      pend_r <= issue_s;
      if (issue_s) begin
        pend_pc_r   <= pc_f_r;
        pend_adel_r <= addr_misaligned(pc_f_r);
      end
      // A misaligned slot never reads the SRAM, so its word is forced to zero
      if (flush_s) begin
        inst_validD <= 1'b0;
        adelD       <= 1'b0;
        skid_full_r <= 1'b0;
      end else if (stallD) begin
        if (pend_r) begin
          skid_full_r <= 1'b1;
          skid_inst_r <= ret_inst_s;
          skid_pc_r   <= pend_pc_r;
          skid_adel_r <= pend_adel_r;
        end
      end else if (skid_full_r) begin
        instD       <= skid_inst_r;
        pcD         <= skid_pc_r;
        adelD       <= skid_adel_r;
        inst_validD <= 1'b1;
        skid_full_r <= 1'b0;
      end else if (pend_r) begin
        instD       <= ret_inst_s;
        pcD         <= pend_pc_r;
        adelD       <= pend_adel_r;
        inst_validD <= 1'b1;
      end else begin
        inst_validD <= 1'b0;
      end
    end
  end

endmodule
